// File: rtl/kernel_pr_arb_pkg.sv
// Shared types and helpers for the kernel_pr round-robin FIFO arbiter.
package kernel_pr_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // Lane index following ptr, wrapping at n (n need not be a power of two).
   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
      return (ptr + 1 >= n) ? 32'd0 : ptr + 1;
   endfunction

endpackage

// File: rtl/kernel_pr_rr_pick.sv
// Rotating-priority picker: first requesting lane at or after ptr, wrapping at NUM_IN.
module kernel_pr_rr_pick #(
   parameter int NUM_IN = 4,
   parameter int SRC_W  = 2
) (
   input  logic [NUM_IN-1:0] req,
   input  logic [SRC_W-1:0]  ptr,
   output logic [SRC_W-1:0]  gnt,
   output logic              any
);

   localparam logic [SRC_W:0] N_W = (SRC_W + 1)'(NUM_IN);

   logic [2*NUM_IN-1:0] req2;
   logic [NUM_IN-1:0]   rot;
   logic [SRC_W-1:0]    off;
   logic [SRC_W:0]      sum;

   // Rotate so bit 0 of rot is lane ptr; the lowest set bit is the winner's offset.
   assign req2 = {req, req};
   assign rot  = NUM_IN'(req2 >> ptr);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      any = 1'b0;
      off = '0;
      for (int i = NUM_IN - 1; i >= 0; i--) begin
         if (rot[i]) begin
            any = 1'b1;
            off = SRC_W'(i);
         end
      end
   end

   assign sum = {1'b0, ptr} + {1'b0, off};
   assign gnt = (sum >= N_W) ? SRC_W'(sum - N_W) : sum[SRC_W-1:0];

endmodule

// File: rtl/kernel_pr_fifo_rr_arbiter.sv
// Round-robin burst arbiter merging NUM_IN ap_fifo read sides into one registered,
// source-tagged FIFO write port.
module kernel_pr_fifo_rr_arbiter
   import kernel_pr_arb_pkg::*;
#(
   parameter int NUM_IN     = 4,
   parameter int SRC_W      = 2,
   parameter int DATA_WIDTH = 32,
   parameter int BURST_MAX  = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         en,
   input  logic [NUM_IN-1:0]            in_empty_n,
   output logic [NUM_IN-1:0]            in_read,
   input  logic [NUM_IN*DATA_WIDTH-1:0] in_dout,
   input  logic                         out_full_n,
   output logic                         out_write,
   output logic [DATA_WIDTH-1:0]        out_din,
   output logic [SRC_W-1:0]             out_src,
   output logic [31:0]                  out_count,
   output logic                         busy
);

   localparam logic [7:0] LAST_BEAT = 8'(BURST_MAX - 1);

   arb_state_t            state;
   arb_state_t            state_nxt;
   logic [SRC_W-1:0]      gnt;
   logic [SRC_W-1:0]      rr_ptr;
   logic [SRC_W-1:0]      pick_gnt;
   logic                  pick_any;
   logic [7:0]            burst_cnt;
   logic                  out_ok;
   logic                  lane_ready;
   logic                  rd;
   logic                  start;
   logic                  rotate;
   logic [DATA_WIDTH-1:0] lane_data;

   kernel_pr_rr_pick #(
      .NUM_IN (NUM_IN),
      .SRC_W  (SRC_W)
   ) u_pick (
      .req (in_empty_n),
      .ptr (rr_ptr),
      .gnt (pick_gnt),
      .any (pick_any)
   );

   // The output register can take a new beat when empty or draining this cycle.
   assign out_ok     = ~out_write | out_full_n;
   assign lane_ready = in_empty_n[gnt];
   assign rd         = (state == GRANT) & en & lane_ready & out_ok;
   assign start      = (state == IDLE) & en & (|in_empty_n) & pick_any;
   // Burst ends on its last beat or when the granted lane runs dry; en=0 keeps the pointer.
   assign rotate     = (state == GRANT) & en &
                       (~lane_ready | (rd & (burst_cnt == LAST_BEAT)));

   always_comb begin
      in_read   = '0;
      lane_data = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (gnt == SRC_W'(i)) begin
            in_read[i] = rd;
            lane_data  = in_dout[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = GRANT;
         GRANT:   if (!en || rotate) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         gnt       <= '0;
         rr_ptr    <= '0;
         burst_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (start) begin
            gnt       <= pick_gnt;
            burst_cnt <= '0;
         end else if (rd) begin
            burst_cnt <= burst_cnt + 8'd1;
         end
         if (rotate) rr_ptr <= SRC_W'(rr_next(32'(gnt), NUM_IN));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_write <= 1'b0;
         out_din   <= '0;
         out_src   <= '0;
         out_count <= '0;
      end else begin
         if (out_write && out_full_n) out_count <= out_count + 32'd1;
         if (rd) begin
            out_write <= 1'b1;
            out_din   <= lane_data;
            out_src   <= gnt;
         end else if (out_full_n) begin
            out_write <= 1'b0;
         end
      end
   end

   assign busy = (state != IDLE) | out_write;

endmodule

// File: tb/tb_kernel_pr_fifo_rr_arbiter.sv
// Self-checking bench: TB-owned lane FIFOs, read scoreboard, per-scenario grant traces.
module tb_kernel_pr_fifo_rr_arbiter;

   localparam int NUM_IN    = 4;
   localparam int SRC_W     = 2;
   localparam int DW        = 32;
   localparam int BURST_MAX = 8;

   typedef struct {
      int            lane;
      logic [DW-1:0] data;
   } beat_t;

   typedef struct {
      logic [NUM_IN-1:0] rd;
      logic              wr;
      logic [DW-1:0]     din;
      logic [SRC_W-1:0]  src;
   } obs_t;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 en = 1'b0;
   logic                 out_full_n = 1'b1;
   logic [NUM_IN-1:0]    in_empty_n = '0;
   logic [NUM_IN-1:0]    in_read;
   logic [NUM_IN*DW-1:0] in_dout = '0;
   logic                 out_write;
   logic [DW-1:0]        out_din;
   logic [SRC_W-1:0]     out_src;
   logic [31:0]          out_count;
   logic                 busy;

   logic [DW-1:0] lane_q [NUM_IN][$];
   beat_t         exp_q[$];
   obs_t          trace[$];
   int            n_cmp = 0;
   int            n_err = 0;
   int            model_xfers = 0;
   int            run_len = 0;
   int            run_lane = -1;

   kernel_pr_fifo_rr_arbiter #(
      .NUM_IN     (NUM_IN),
      .SRC_W      (SRC_W),
      .DATA_WIDTH (DW),
      .BURST_MAX  (BURST_MAX)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .in_empty_n (in_empty_n),
      .in_read    (in_read),
      .in_dout    (in_dout),
      .out_full_n (out_full_n),
      .out_write  (out_write),
      .out_din    (out_din),
      .out_src    (out_src),
      .out_count  (out_count),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

   task automatic drive_lanes();
      for (int i = 0; i < NUM_IN; i++) begin
         in_empty_n[i]        = (lane_q[i].size() != 0);
         in_dout[i*DW +: DW]  = (lane_q[i].size() != 0) ? lane_q[i][0] : '0;
      end
   endtask

   task automatic load_lane(input int lane, input int n);
      for (int k = 0; k < n; k++) lane_q[lane].push_back($urandom);
   endtask

   function automatic bit lanes_pending();
      for (int i = 0; i < NUM_IN; i++) if (lane_q[i].size() != 0) return 1'b1;
      return 1'b0;
   endfunction

   // One clock: sample at negedge, check legality and transfers, then pop read lanes.
   task automatic cycle();
      obs_t              o;
      beat_t             e;
      beat_t             b;
      int                lane;
      logic [NUM_IN-1:0] rd_now;
      @(negedge clk);
      o.rd = in_read; o.wr = out_write; o.din = out_din; o.src = out_src;
      trace.push_back(o);
      n_cmp++;
      if (!$onehot0(in_read) || ((in_read & ~in_empty_n) != '0)) begin
         n_err++;
         $display("FAIL read_legal: in_read=%b in_empty_n=%b, need <=1 hot on a non-empty lane",
                  in_read, in_empty_n);
      end
      if (in_read != '0) begin
         lane = 0;
         for (int i = 0; i < NUM_IN; i++) if (in_read[i]) lane = i;
         if (lane == run_lane) run_len++;
         else begin
            run_lane = lane;
            run_len  = 1;
         end
         n_cmp++;
         if (run_len > BURST_MAX) begin
            n_err++;
            $display("FAIL burst_len: lane %0d read %0d cycles in a row, limit %0d",
                     lane, run_len, BURST_MAX);
         end
      end else begin
         run_lane = -1;
         run_len  = 0;
      end
      if (out_write && out_full_n) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL out_extra: beat din=%h src=%0d with nothing expected", out_din, out_src);
         end else begin
            e = exp_q.pop_front();
            if (out_din !== e.data || out_src !== SRC_W'(e.lane)) begin
               n_err++;
               $display("FAIL out_beat: got din=%h src=%0d, expected din=%h src=%0d",
                        out_din, out_src, e.data, e.lane);
            end
         end
         model_xfers++;
      end
      rd_now = in_read;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_IN; i++) begin
         if (rd_now[i] && lane_q[i].size() != 0) begin
            b.lane = i;
            b.data = lane_q[i].pop_front();
            exp_q.push_back(b);
         end
      end
      drive_lanes();
   endtask

   task automatic drain(input string name);
      int k;
      en = 1'b1;
      out_full_n = 1'b1;
      k = 0;
      while ((lanes_pending() || busy || exp_q.size() != 0) && k < 400) begin
         cycle();
         k++;
      end
      n_cmp++;
      if (k >= 400 || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL %s_drain: %0d beats still expected after %0d cycles, need 0",
                  name, exp_q.size(), k);
      end
      n_cmp++;
      if (out_count !== 32'(model_xfers)) begin
         n_err++;
         $display("FAIL %s_count: out_count=%0d expected %0d", name, out_count, model_xfers);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      en = 1'b0;
      out_full_n = 1'b1;
      for (int i = 0; i < NUM_IN; i++) lane_q[i].delete();
      exp_q.delete();
      trace.delete();
      model_xfers = 0;
      run_len = 0;
      run_lane = -1;
      drive_lanes();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      en = 1'b1;
      load_lane(1, 2);
      drive_lanes();
      #2;
      n_cmp += 6;
      if (out_write !== 1'b0) begin n_err++; $display("FAIL rst_out_write: got %b expected 0", out_write); end
      if (out_din !== '0)     begin n_err++; $display("FAIL rst_out_din: got %h expected 0", out_din); end
      if (out_src !== '0)     begin n_err++; $display("FAIL rst_out_src: got %0d expected 0", out_src); end
      if (out_count !== '0)   begin n_err++; $display("FAIL rst_out_count: got %0d expected 0", out_count); end
      if (busy !== 1'b0)      begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy); end
      if (in_read !== '0)     begin n_err++; $display("FAIL rst_in_read: got %b expected 0", in_read); end
      do_reset();
   endtask

   task automatic test_single_lane();
      logic [DW-1:0]     w [3];
      logic [NUM_IN-1:0] exp_rd;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         w[k] = $urandom;
         lane_q[2].push_back(w[k]);
      end
      en = 1'b1;
      drive_lanes();
      repeat (7) cycle();
      for (int c = 0; c < 7; c++) begin
         exp_rd = (c >= 1 && c <= 3) ? 4'b0100 : 4'b0000;
         n_cmp += 2;
         if (trace[c].rd !== exp_rd) begin
            n_err++;
            $display("FAIL single_rd c%0d: got %b expected %b", c, trace[c].rd, exp_rd);
         end
         if (trace[c].wr !== (c >= 2 && c <= 4)) begin
            n_err++;
            $display("FAIL single_wr c%0d: got %b expected %b", c, trace[c].wr, (c >= 2 && c <= 4));
         end
         if (c >= 2 && c <= 4) begin
            n_cmp++;
            if (trace[c].din !== w[c-2] || trace[c].src !== 2'd2) begin
               n_err++;
               $display("FAIL single_beat c%0d: got din=%h src=%0d expected din=%h src=2",
                        c, trace[c].din, trace[c].src, w[c-2]);
            end
         end
      end
      n_cmp++;
      if (out_count !== 32'd3) begin
         n_err++;
         $display("FAIL single_count: got %0d expected 3", out_count);
      end
   endtask

   task automatic test_all_lanes();
      logic [NUM_IN-1:0] exp_rd[$];
      do_reset();
      for (int i = 0; i < NUM_IN; i++) load_lane(i, 2 * BURST_MAX);
      en = 1'b1;
      drive_lanes();
      exp_rd.push_back('0);
      for (int b = 0; b < 5; b++) begin
         repeat (BURST_MAX) exp_rd.push_back(NUM_IN'(1) << (b % NUM_IN));
         exp_rd.push_back('0);
      end
      repeat (exp_rd.size()) cycle();
      for (int c = 0; c < exp_rd.size(); c++) begin
         n_cmp++;
         if (trace[c].rd !== exp_rd[c]) begin
            n_err++;
            $display("FAIL all_lanes_rd c%0d: got %b expected %b", c, trace[c].rd, exp_rd[c]);
         end
      end
      drain("all_lanes");
   endtask

   task automatic test_backpressure();
      obs_t o;
      do_reset();
      load_lane(0, BURST_MAX);
      en = 1'b1;
      drive_lanes();
      repeat (4) cycle();
      out_full_n = 1'b0;
      repeat (5) begin
         cycle();
         o = trace[trace.size()-1];
         n_cmp += 2;
         if (o.rd !== '0 || o.wr !== 1'b1) begin
            n_err++;
            $display("FAIL stall_ctl: got in_read=%b out_write=%b expected 0000/1", o.rd, o.wr);
         end
         if (exp_q.size() != 1 || o.din !== exp_q[0].data || o.src !== 2'd0) begin
            n_err++;
            $display("FAIL stall_hold: got din=%h src=%0d, pending=%0d expected one held lane 0 beat",
                     o.din, o.src, exp_q.size());
         end
      end
      drain("backpressure");
      n_cmp++;
      if (model_xfers != BURST_MAX) begin
         n_err++;
         $display("FAIL stall_total: got %0d beats expected %0d", model_xfers, BURST_MAX);
      end
   endtask

   task automatic test_lane_empty_early();
      logic [NUM_IN-1:0] exp_rd[$];
      do_reset();
      load_lane(1, 3);
      load_lane(2, 4);
      en = 1'b1;
      drive_lanes();
      cycle();
      load_lane(0, 2);
      drive_lanes();
      exp_rd.push_back('0);
      repeat (3) exp_rd.push_back(4'b0010);
      repeat (2) exp_rd.push_back('0);
      repeat (4) exp_rd.push_back(4'b0100);
      repeat (2) exp_rd.push_back('0);
      repeat (2) exp_rd.push_back(4'b0001);
      exp_rd.push_back('0);
      repeat (exp_rd.size() - 1) cycle();
      for (int c = 0; c < exp_rd.size(); c++) begin
         n_cmp++;
         if (trace[c].rd !== exp_rd[c]) begin
            n_err++;
            $display("FAIL early_empty_rd c%0d: got %b expected %b", c, trace[c].rd, exp_rd[c]);
         end
      end
      drain("early_empty");
   endtask

   task automatic test_en_drop();
      logic [NUM_IN-1:0] exp_rd[$];
      do_reset();
      load_lane(2, 1);
      en = 1'b1;
      drive_lanes();
      repeat (4) cycle();
      load_lane(3, 6);
      load_lane(0, 4);
      drive_lanes();
      trace.delete();
      repeat (3) cycle();
      en = 1'b0;
      repeat (3) cycle();
      en = 1'b1;
      repeat (13) cycle();
      exp_rd.push_back('0);
      repeat (2) exp_rd.push_back(4'b1000);
      repeat (4) exp_rd.push_back('0);
      repeat (4) exp_rd.push_back(4'b1000);
      repeat (2) exp_rd.push_back('0);
      repeat (4) exp_rd.push_back(4'b0001);
      repeat (2) exp_rd.push_back('0);
      for (int c = 0; c < exp_rd.size(); c++) begin
         n_cmp++;
         if (trace[c].rd !== exp_rd[c]) begin
            n_err++;
            $display("FAIL en_drop_rd c%0d: got %b expected %b", c, trace[c].rd, exp_rd[c]);
         end
      end
      n_cmp += 2;
      if (trace[3].wr !== 1'b1) begin
         n_err++;
         $display("FAIL en_drop_pending: out_write=%b expected 1", trace[3].wr);
      end
      if (trace[4].wr !== 1'b0) begin
         n_err++;
         $display("FAIL en_drop_drained: out_write=%b expected 0", trace[4].wr);
      end
      drain("en_drop");
   endtask

   // Runs straight after test_en_drop, whose last burst leaves the pointer at lane 1.
   task automatic test_async_reset();
      load_lane(2, BURST_MAX);
      load_lane(0, BURST_MAX);
      en = 1'b1;
      drive_lanes();
      trace.delete();
      repeat (4) cycle();
      n_cmp += 2;
      if (trace[1].rd !== 4'b0100) begin
         n_err++;
         $display("FAIL areset_pre_grant: got %b expected 0100", trace[1].rd);
      end
      if (trace[3].wr !== 1'b1) begin
         n_err++;
         $display("FAIL areset_pre_wr: got %b expected 1", trace[3].wr);
      end
      #2;
      reset = 1'b1;
      #1;
      n_cmp += 3;
      if (out_write !== 1'b0) begin n_err++; $display("FAIL areset_wr: got %b expected 0", out_write); end
      if (out_count !== '0)   begin n_err++; $display("FAIL areset_count: got %0d expected 0", out_count); end
      if (busy !== 1'b0)      begin n_err++; $display("FAIL areset_busy: got %b expected 0", busy); end
      @(negedge clk);
      #2;
      reset = 1'b0;
      exp_q.delete();
      model_xfers = 0;
      run_len = 0;
      run_lane = -1;
      trace.delete();
      cycle();
      n_cmp++;
      if (trace[0].rd !== 4'b0001) begin
         n_err++;
         $display("FAIL areset_first_grant: got %b expected 0001", trace[0].rd);
      end
      drain("areset");
   endtask

   task automatic test_random();
      int lane;
      do_reset();
      for (int n = 0; n < 800; n++) begin
         en         = ($urandom_range(0, 9) != 0);
         out_full_n = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 2) == 0) begin
            lane = int'($urandom_range(0, NUM_IN - 1));
            if (lane_q[lane].size() < 12) lane_q[lane].push_back($urandom);
         end
         drive_lanes();
         cycle();
      end
      drain("random");
   endtask

   initial begin
      test_reset();
      test_single_lane();
      test_all_lanes();
      test_backpressure();
      test_lane_empty_early();
      test_en_drop();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
